// File: rtl/psg_pkg.sv
// Shared constants for the SN76489-compatible PSG register front end:
// internal register addresses, the silent attenuation code and the
// position of the latch/data flag inside a CPU write byte.
package psg_pkg;

   localparam logic [2:0] TONE0 = 3'd0;
   localparam logic [2:0] ATT0  = 3'd1;
   localparam logic [2:0] TONE1 = 3'd2;
   localparam logic [2:0] ATT1  = 3'd3;
   localparam logic [2:0] TONE2 = 3'd4;
   localparam logic [2:0] ATT2  = 3'd5;
   localparam logic [2:0] NOISE = 3'd6;
   localparam logic [2:0] ATT3  = 3'd7;

   localparam logic [3:0] ATT_SILENT = 4'hF;

   localparam int LATCH_BIT       = 7;
   localparam int NOISE_CTRL_BITS = 3;

endpackage

// File: rtl/psg_busy_timer.sv
// READY model for the PSG: an accepted write reloads a down-counter and
// READY stays low until the counter has drained back to zero.
module psg_busy_timer #(
   parameter int BUSY_CYCLES = 32
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_load,
   output logic o_ready
);

   localparam int CW = $clog2(BUSY_CYCLES + 1);

   logic [CW-1:0] r_count;

   // Reload on an accepted write, otherwise drain toward zero and hold there
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CW'(BUSY_CYCLES);
      end else if (r_count != '0) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_ready = (r_count == '0);

endmodule

// File: rtl/psg_register_decoder.sv
// CPU write decoder for the SN76489-compatible PSG. Interprets latch and
// data bytes, holds the eight sound registers, raises restart_noise when the
// noise control register is written and reports writes lost while busy.
module psg_register_decoder
   import psg_pkg::*;
#(
   parameter int COUNTER_BITS = 10,
   parameter int BUSY_CYCLES  = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr,
   input  logic [7:0]                 data,
   output logic                       ready,
   output logic                       write_dropped,
   output logic [COUNTER_BITS-1:0]    tone0_freq,
   output logic [COUNTER_BITS-1:0]    tone1_freq,
   output logic [COUNTER_BITS-1:0]    tone2_freq,
   output logic [3:0]                 att0,
   output logic [3:0]                 att1,
   output logic [3:0]                 att2,
   output logic [3:0]                 att3,
   output logic [NOISE_CTRL_BITS-1:0] noise_control,
   output logic                       restart_noise
);

   logic                       w_ready;
   logic                       w_accept;
   logic                       w_isLatch;
   logic [2:0]                 w_target;

   logic [2:0]                 r_addr;
   logic [COUNTER_BITS-1:0]    r_tone0;
   logic [COUNTER_BITS-1:0]    r_tone1;
   logic [COUNTER_BITS-1:0]    r_tone2;
   logic [3:0]                 r_att0;
   logic [3:0]                 r_att1;
   logic [3:0]                 r_att2;
   logic [3:0]                 r_att3;
   logic [NOISE_CTRL_BITS-1:0] r_noise;
   logic                       r_restartNoise;
   logic                       r_writeDropped;

   assign w_accept  = wr & w_ready;
   assign w_isLatch = data[LATCH_BIT];
   assign w_target  = w_isLatch ? data[6:4] : r_addr;

   psg_busy_timer #(
      .BUSY_CYCLES (BUSY_CYCLES)
   ) u_busyTimer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_accept),
      .o_ready (w_ready)
   );

   // Apply accepted bytes to the addressed register; a latch byte writes the
   // low tone nibble, a data byte writes the upper six tone bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr         <= TONE0;
         r_tone0        <= '0;
         r_tone1        <= '0;
         r_tone2        <= '0;
         r_att0         <= ATT_SILENT;
         r_att1         <= ATT_SILENT;
         r_att2         <= ATT_SILENT;
         r_att3         <= ATT_SILENT;
         r_noise        <= '0;
         r_restartNoise <= 1'b0;
         r_writeDropped <= 1'b0;
      end else begin
         r_restartNoise <= 1'b0;
         r_writeDropped <= wr & ~w_ready;
         if (w_accept) begin
            if (w_isLatch) begin
               r_addr <= data[6:4];
            end
            case (w_target)
               TONE0: begin
                  if (w_isLatch) r_tone0[3:0] <= data[3:0];
                  else           r_tone0[COUNTER_BITS-1:4] <= data[COUNTER_BITS-5:0];
               end
               TONE1: begin
                  if (w_isLatch) r_tone1[3:0] <= data[3:0];
                  else           r_tone1[COUNTER_BITS-1:4] <= data[COUNTER_BITS-5:0];
               end
               TONE2: begin
                  if (w_isLatch) r_tone2[3:0] <= data[3:0];
                  else           r_tone2[COUNTER_BITS-1:4] <= data[COUNTER_BITS-5:0];
               end
               ATT0: r_att0 <= data[3:0];
               ATT1: r_att1 <= data[3:0];
               ATT2: r_att2 <= data[3:0];
               ATT3: r_att3 <= data[3:0];
               NOISE: begin
                  r_noise        <= data[NOISE_CTRL_BITS-1:0];
                  r_restartNoise <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign ready         = w_ready;
   assign write_dropped = r_writeDropped;
   assign tone0_freq    = r_tone0;
   assign tone1_freq    = r_tone1;
   assign tone2_freq    = r_tone2;
   assign att0          = r_att0;
   assign att1          = r_att1;
   assign att2          = r_att2;
   assign att3          = r_att3;
   assign noise_control = r_noise;
   assign restart_noise = r_restartNoise;

endmodule

// File: tb/tb_psg_register_decoder.sv
// Directed bench for the PSG register decoder: a table of write bytes with
// the full register state expected after each one, then hand-built
// sequences for the busy window, dropped writes and reset during busy.
module tb_psg_register_decoder;

   logic       clk;
   logic       reset_n;
   logic       wr;
   logic [7:0] data;
   logic       ready;
   logic       write_dropped;
   logic [9:0] tone0_freq;
   logic [9:0] tone1_freq;
   logic [9:0] tone2_freq;
   logic [3:0] att0;
   logic [3:0] att1;
   logic [3:0] att2;
   logic [3:0] att3;
   logic [2:0] noise_control;
   logic       restart_noise;

   int passCount;
   int checkCount;

   typedef struct {
      logic [7:0] data;
      logic [9:0] t0;
      logic [9:0] t1;
      logic [9:0] t2;
      logic [3:0] a0;
      logic [3:0] a1;
      logic [3:0] a2;
      logic [3:0] a3;
      logic [2:0] nc;
      logic       rs;
   } vec_t;

   vec_t vecs[16];

   psg_register_decoder #(
      .COUNTER_BITS (10),
      .BUSY_CYCLES  (32)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr            (wr),
      .data          (data),
      .ready         (ready),
      .write_dropped (write_dropped),
      .tone0_freq    (tone0_freq),
      .tone1_freq    (tone1_freq),
      .tone2_freq    (tone2_freq),
      .att0          (att0),
      .att1          (att1),
      .att2          (att2),
      .att3          (att3),
      .noise_control (noise_control),
      .restart_noise (restart_noise)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one byte for a single clock edge; returns #1 after that edge
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      wr   = 1'b1;
      data = b;
      @(posedge clk);
      #1;
      wr = 1'b0;
   endtask

   task automatic waitReady();
      int n;
      n = 0;
      while (!ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("ready_returns", 16'(ready), 16'd1);
   endtask

   task automatic checkState(input string tag, input vec_t v);
      checkOutput({tag, "_tone0"}, 16'(tone0_freq), 16'(v.t0));
      checkOutput({tag, "_tone1"}, 16'(tone1_freq), 16'(v.t1));
      checkOutput({tag, "_tone2"}, 16'(tone2_freq), 16'(v.t2));
      checkOutput({tag, "_att0"}, 16'(att0), 16'(v.a0));
      checkOutput({tag, "_att1"}, 16'(att1), 16'(v.a1));
      checkOutput({tag, "_att2"}, 16'(att2), 16'(v.a2));
      checkOutput({tag, "_att3"}, 16'(att3), 16'(v.a3));
      checkOutput({tag, "_noise"}, 16'(noise_control), 16'(v.nc));
      checkOutput({tag, "_restart"}, 16'(restart_noise), 16'(v.rs));
   endtask

   initial begin
      vec_t resetState;
      int   readyLow;
      int   drops;
      int   corrupt;
      string tag;

      passCount  = 0;
      checkCount = 0;
      wr         = 1'b0;
      data       = 8'h00;
      reset_n    = 1'b0;

      resetState = '{8'h00, 10'h000, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0};

      vecs[0]  = '{8'h8E, 10'h00E, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0};
      vecs[1]  = '{8'h0F, 10'h0FE, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0};
      vecs[2]  = '{8'hBF, 10'h0FE, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0};
      vecs[3]  = '{8'h03, 10'h0FE, 10'h000, 10'h000, 4'hF, 4'h3, 4'hF, 4'hF, 3'd0, 1'b0};
      vecs[4]  = '{8'hE5, 10'h0FE, 10'h000, 10'h000, 4'hF, 4'h3, 4'hF, 4'hF, 3'd5, 1'b1};
      vecs[5]  = '{8'h02, 10'h0FE, 10'h000, 10'h000, 4'hF, 4'h3, 4'hF, 4'hF, 3'd2, 1'b1};
      vecs[6]  = '{8'h90, 10'h0FE, 10'h000, 10'h000, 4'h0, 4'h3, 4'hF, 4'hF, 3'd2, 1'b0};
      vecs[7]  = '{8'hC5, 10'h0FE, 10'h000, 10'h005, 4'h0, 4'h3, 4'hF, 4'hF, 3'd2, 1'b0};
      vecs[8]  = '{8'h7F, 10'h0FE, 10'h000, 10'h3F5, 4'h0, 4'h3, 4'hF, 4'hF, 3'd2, 1'b0};
      vecs[9]  = '{8'hA9, 10'h0FE, 10'h009, 10'h3F5, 4'h0, 4'h3, 4'hF, 4'hF, 3'd2, 1'b0};
      vecs[10] = '{8'hF8, 10'h0FE, 10'h009, 10'h3F5, 4'h0, 4'h3, 4'hF, 4'h8, 3'd2, 1'b0};
      vecs[11] = '{8'h41, 10'h0FE, 10'h009, 10'h3F5, 4'h0, 4'h3, 4'hF, 4'h1, 3'd2, 1'b0};
      vecs[12] = '{8'hEB, 10'h0FE, 10'h009, 10'h3F5, 4'h0, 4'h3, 4'hF, 4'h1, 3'd3, 1'b1};
      vecs[13] = '{8'h83, 10'h0F3, 10'h009, 10'h3F5, 4'h0, 4'h3, 4'hF, 4'h1, 3'd3, 1'b0};
      vecs[14] = '{8'hD7, 10'h0F3, 10'h009, 10'h3F5, 4'h0, 4'h3, 4'h7, 4'h1, 3'd3, 1'b0};
      vecs[15] = '{8'h22, 10'h0F3, 10'h009, 10'h3F5, 4'h0, 4'h3, 4'h2, 4'h1, 3'd3, 1'b0};

      // Power-on reset defaults
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkState("reset", resetState);
      checkOutput("reset_ready", 16'(ready), 16'd1);
      checkOutput("reset_dropped", 16'(write_dropped), 16'd0);

      // Table: one accepted byte per row, full state checked right after
      for (int i = 0; i < 16; i++) begin
         tag = $sformatf("row%0d", i);
         applyStimulus(vecs[i].data);
         checkState(tag, vecs[i]);
         checkOutput({tag, "_busy"}, 16'(ready), 16'd0);
         checkOutput({tag, "_dropped"}, 16'(write_dropped), 16'd0);
         @(posedge clk);
         #1;
         checkOutput({tag, "_restart_gone"}, 16'(restart_noise), 16'd0);
         waitReady();
      end

      // Counter stays at zero once drained
      repeat (6) @(posedge clk);
      #1;
      checkOutput("idle_ready", 16'(ready), 16'd1);

      // Held write: one accept, 32 busy cycles each dropping, accept again
      @(negedge clk);
      wr   = 1'b1;
      data = 8'h8A;
      @(posedge clk);
      #1;
      checkOutput("hold_first_tone0", 16'(tone0_freq), 16'h0FA);
      readyLow = (ready == 1'b0) ? 1 : 0;
      drops    = (write_dropped == 1'b1) ? 1 : 0;
      corrupt  = 0;
      @(negedge clk);
      data = 8'h3F;
      for (int e = 1; e <= 32; e++) begin
         @(posedge clk);
         #1;
         if (ready == 1'b0) readyLow++;
         if (write_dropped == 1'b1) drops++;
         if (tone0_freq !== 10'h0FA) corrupt++;
      end
      checkOutput("hold_ready_low_cycles", 16'(readyLow), 16'd32);
      checkOutput("hold_dropped_pulses", 16'(drops), 16'd32);
      checkOutput("hold_no_corruption", 16'(corrupt), 16'd0);
      @(posedge clk);
      #1;
      wr = 1'b0;
      checkOutput("hold_reaccept_tone0", 16'(tone0_freq), 16'h3FA);
      checkOutput("hold_reaccept_busy", 16'(ready), 16'd0);
      checkOutput("hold_reaccept_no_drop", 16'(write_dropped), 16'd0);
      waitReady();

      // Reset asserted five cycles into a busy window
      applyStimulus(8'hE6);
      checkOutput("mid_noise", 16'(noise_control), 16'd6);
      checkOutput("mid_restart", 16'(restart_noise), 16'd1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("mid_busy_before_reset", 16'(ready), 16'd0);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_reset_ready", 16'(ready), 16'd1);
      checkState("mid_reset", resetState);
      checkOutput("mid_reset_dropped", 16'(write_dropped), 16'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(8'h9C);
      checkOutput("post_reset_att0", 16'(att0), 16'hC);
      checkOutput("post_reset_busy", 16'(ready), 16'd0);
      checkOutput("post_reset_no_drop", 16'(write_dropped), 16'd0);
      waitReady();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
